rtc_access_scheduler: RTL and testbench

//  Owns the multiplexed RTC bus (CS/RD/WR/AD, 8-bit DatAdd) and schedules every access to it.

---
 rtl/rtc_bus_pkg.sv | 34 +++
 rtl/rtc_bus_phase.sv | 122 ++++++++++++
 rtl/rtc_access_scheduler.sv | 106 ++++++++++
 tb/tb_rtc_access_scheduler.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC bus: access phase encoding, idle pin levels and
// the burst-index to register-address map.
package rtc_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_GAP     = 3'd2,
    ST_DATA    = 3'd3,
    ST_RECOVER = 3'd4
  } phase_state_t;

  localparam logic       BUS_STROBE_IDLE = 1'b1;
  localparam logic [7:0] BUS_DATA_IDLE   = 8'h00;

  // Burst index -> RTC register: time/date block first, then the timer block
  function automatic logic [7:0] reg_addr(input logic [3:0] idx);
    logic [7:0] a;
    case (idx)
      4'd0:    a = 8'h21;
      4'd1:    a = 8'h22;
      4'd2:    a = 8'h23;
      4'd3:    a = 8'h24;
      4'd4:    a = 8'h25;
      4'd5:    a = 8'h26;
      4'd6:    a = 8'h31;
      4'd7:    a = 8'h32;
      4'd8:    a = 8'h33;
      default: a = 8'h21;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/rtc_bus_phase.sv
// Single-access timing engine for the RTC bus: ADDR -> GAP -> DATA -> RECOVER,
// all timed by one down-counter, with the pin drive decoded from the phase state.
module rtc_bus_phase
  import rtc_bus_pkg::*;
#(
  parameter int unsigned PHASE_CYC = 8,
  parameter int unsigned GAP_CYC   = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         is_write,
  input  logic [7:0]   addr,
  input  logic [7:0]   wdata,
  input  logic [3:0]   tag,
  input  logic [7:0]   dat_in,
  output logic         CS,
  output logic         RD,
  output logic         WR,
  output logic         AD,
  output logic [7:0]   dat_out,
  output logic         dat_oe,
  output logic         done,
  output logic         rvalid,
  output logic [7:0]   rdata,
  output logic [3:0]   rtag,
  output phase_state_t state
);

  localparam int unsigned MAX_CYC = (PHASE_CYC > GAP_CYC) ? PHASE_CYC : GAP_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;
  localparam logic [CNT_W-1:0] PHASE_LOAD = CNT_W'(PHASE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYC - 1);

  phase_state_t     state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             last, accept, capture;
  logic [7:0]       addr_q, wdata_q;
  logic             write_q;
  logic [3:0]       tag_q;

  assign last    = (cnt == '0);
  // A new access may begin from IDLE or straight out of the final RECOVER cycle
  assign accept  = start && ((state == ST_IDLE) || ((state == ST_RECOVER) && last));
  assign done    = (state == ST_RECOVER) && last;
  assign capture = (state == ST_DATA) && last && !write_q;

  always_comb begin
    state_n = state;
    cnt_n   = last ? cnt : cnt - CNT_W'(1);
    case (state)
      ST_IDLE:    if (accept) begin state_n = ST_ADDR;    cnt_n = PHASE_LOAD; end
      ST_ADDR:    if (last)   begin state_n = ST_GAP;     cnt_n = GAP_LOAD;   end
      ST_GAP:     if (last)   begin state_n = ST_DATA;    cnt_n = PHASE_LOAD; end
      ST_DATA:    if (last)   begin state_n = ST_RECOVER; cnt_n = GAP_LOAD;   end
      ST_RECOVER: if (last) begin
        if (accept) begin state_n = ST_ADDR; cnt_n = PHASE_LOAD; end
        else        state_n = ST_IDLE;
      end
      default:    state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      tag_q   <= '0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rtag    <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      rvalid <= capture;
      if (accept) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        write_q <= is_write;
        tag_q   <= tag;
      end
      if (capture) begin
        rdata <= dat_in;
        rtag  <= tag_q;
      end
    end
  end

  // CS is low only while ADDR or DATA actually drives the bus
  always_comb begin
    CS      = BUS_STROBE_IDLE;
    RD      = BUS_STROBE_IDLE;
    WR      = BUS_STROBE_IDLE;
    AD      = BUS_STROBE_IDLE;
    dat_oe  = 1'b0;
    dat_out = BUS_DATA_IDLE;
    case (state)
      ST_ADDR: begin
        CS      = 1'b0;
        WR      = 1'b0;
        AD      = 1'b0;
        dat_oe  = 1'b1;
        dat_out = addr_q;
      end
      ST_DATA: begin
        CS = 1'b0;
        if (write_q) begin
          WR      = 1'b0;
          dat_oe  = 1'b1;
          dat_out = wdata_q;
        end else begin
          RD = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rtc_access_scheduler.sv
// Owns the RTC bus: periodic refresh bursts over the time/timer registers with
// one-shot edit writes slotted in between reads.
module rtc_access_scheduler
  import rtc_bus_pkg::*;
#(
  parameter int unsigned PHASE_CYC   = 8,
  parameter int unsigned GAP_CYC     = 4,
  parameter int unsigned REFRESH_CYC = 1_000_000,
  parameter int unsigned NUM_REGS    = 9
) (
  input  logic       clk,
  input  logic       reset,
  output logic       CS,
  output logic       RD,
  output logic       WR,
  output logic       AD,
  output logic [7:0] dat_out,
  output logic       dat_oe,
  input  logic [7:0] dat_in,
  input  logic       wr_req,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  output logic       rd_valid,
  output logic [3:0] rd_idx,
  output logic [7:0] rd_data,
  output logic       busy
);

  localparam int unsigned REF_W = $clog2(REFRESH_CYC);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYC - 1);
  localparam logic [3:0]       LAST_IDX = 4'(NUM_REGS - 1);

  phase_state_t     state;
  logic             done;
  logic [REF_W-1:0] ref_cnt;
  logic             tick, refresh_pend, wr_block;
  logic [3:0]       burst_idx, cur_idx;
  logic             cur_write;
  logic             can_arb, burst_end, grant_wr, grant_rd, start;
  logic [7:0]       acc_addr;

  assign tick      = (ref_cnt == REF_LAST);
  assign can_arb   = (state == ST_IDLE) || done;
  assign burst_end = done && !cur_write && (cur_idx == LAST_IDX);
  // Writes beat refresh; a held wr_req is blocked until it has dropped once
  assign grant_wr  = can_arb && wr_req && !wr_block;
  assign grant_rd  = can_arb && !grant_wr && refresh_pend && !burst_end;
  assign start     = grant_wr || grant_rd;
  assign acc_addr  = grant_wr ? wr_addr : reg_addr(burst_idx);
  assign wr_ack    = done && cur_write;
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ref_cnt      <= '0;
      refresh_pend <= 1'b0;
      burst_idx    <= '0;
      wr_block     <= 1'b0;
      cur_idx      <= '0;
      cur_write    <= 1'b0;
    end else begin
      ref_cnt <= tick ? '0 : ref_cnt + REF_W'(1);
      // A tick landing while a burst is pending or running is simply absorbed
      if (burst_end) begin
        refresh_pend <= 1'b0;
        burst_idx    <= '0;
      end else begin
        if (tick) refresh_pend <= 1'b1;
        if (grant_rd) burst_idx <= (burst_idx == LAST_IDX) ? '0 : burst_idx + 4'd1;
      end
      if (!wr_req)       wr_block <= 1'b0;
      else if (grant_wr) wr_block <= 1'b1;
      if (start) begin
        cur_write <= grant_wr;
        cur_idx   <= burst_idx;
      end
    end
  end

  rtc_bus_phase #(
    .PHASE_CYC (PHASE_CYC),
    .GAP_CYC   (GAP_CYC)
  ) u_phase (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .is_write (grant_wr),
    .addr     (acc_addr),
    .wdata    (wr_data),
    .tag      (burst_idx),
    .dat_in   (dat_in),
    .CS       (CS),
    .RD       (RD),
    .WR       (WR),
    .AD       (AD),
    .dat_out  (dat_out),
    .dat_oe   (dat_oe),
    .done     (done),
    .rvalid   (rd_valid),
    .rdata    (rd_data),
    .rtag     (rd_idx),
    .state    (state)
  );

endmodule

// File: tb/tb_rtc_access_scheduler.sv
// Directed bench for rtc_access_scheduler with a behavioural RTC on the bus.
module tb_rtc_access_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       CS, RD, WR, AD, dat_oe, wr_ack, rd_valid, busy;
  logic [7:0] dat_out, dat_in, rd_data;
  logic       wr_req;
  logic [7:0] wr_addr, wr_data;
  logic [3:0] rd_idx;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rel   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rtc_access_scheduler #(
    .PHASE_CYC   (8),
    .GAP_CYC     (4),
    .REFRESH_CYC (200),
    .NUM_REGS    (9)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .CS       (CS),
    .RD       (RD),
    .WR       (WR),
    .AD       (AD),
    .dat_out  (dat_out),
    .dat_oe   (dat_oe),
    .dat_in   (dat_in),
    .wr_req   (wr_req),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ack   (wr_ack),
    .rd_valid (rd_valid),
    .rd_idx   (rd_idx),
    .rd_data  (rd_data),
    .busy     (busy)
  );

  // ---------------- RTC model and bus monitor ----------------
  logic [7:0] mem [256];
  logic [7:0] lat_addr = 8'h00;
  logic [7:0] wr_seen_addr, wr_seen_data;
  bit         model_ready = 1'b0;
  bit         in_addr = 1'b0, in_data = 1'b0;
  int         viol = 0, oe_rd_viol = 0, cs_low = 0, ack_cnt = 0, ack_cyc = 0;
  int         a_len = 0, d_len = 0;
  logic [3:0] rd_idx_q[$];
  logic [7:0] rd_data_q[$];
  int         rd_cyc_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] reg_tbl [9];

  assign dat_in = mem[lat_addr];

  always @(negedge clk) begin
    if (!model_ready) begin
      for (int a = 0; a < 256; a++) mem[a] = 8'(a);
      model_ready = 1'b1;
    end
    if (reset !== 1'b1) begin
      in_addr = 1'b0;
      in_data = 1'b0;
    end else begin
      if (!CS && !AD) begin
        if (!in_addr) a_len = 0;
        in_addr  = 1'b1;
        a_len++;
        lat_addr = dat_out;
        if (WR || !RD || !dat_oe) viol++;
      end else in_addr = 1'b0;
      if (!CS && AD) begin
        if (!in_data) d_len = 0;
        in_data = 1'b1;
        d_len++;
        if (!WR) begin
          mem[lat_addr] = dat_out;
          wr_seen_addr  = lat_addr;
          wr_seen_data  = dat_out;
          if (!RD || !dat_oe) viol++;
        end else if (RD || dat_oe) viol++;
      end else in_data = 1'b0;
      if (CS && (!RD || !WR || !AD || dat_oe)) viol++;
      if (dat_oe && !RD) oe_rd_viol++;
      if (!CS) cs_low++;
      if (rd_valid) begin
        rd_idx_q.push_back(rd_idx);
        rd_data_q.push_back(rd_data);
        rd_cyc_q.push_back(cyc);
      end
      if (wr_ack) begin
        ack_cnt++;
        ack_cyc = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_obs();
    rd_idx_q.delete();
    rd_data_q.delete();
    rd_cyc_q.delete();
    exp_q.delete();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset   = 1'b0;
    wr_req  = 1'b0;
    wr_addr = 8'h00;
    wr_data = 8'h00;
    repeat (3) step();
    total++; if ({CS, RD, WR, AD} !== 4'b1111) begin bad++; $display("FAIL reset_strobes: got %b want 1111", {CS, RD, WR, AD}); end
    total++; if (dat_oe !== 1'b0 || dat_out !== 8'h00) begin bad++; $display("FAIL reset_data: oe=%b out=%h want 0/00", dat_oe, dat_out); end
    total++; if ({wr_ack, rd_valid, busy} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {wr_ack, rd_valid, busy}); end
    total++; if (rd_idx !== 4'd0 || rd_data !== 8'h00) begin bad++; $display("FAIL reset_rd: idx=%0d data=%h want 0/00", rd_idx, rd_data); end
    reset = 1'b1;
    rel   = cyc;
  endtask

  task automatic test_burst();
    int n;
    int cs0;
    clear_obs();
    cs0 = cs_low;
    for (int i = 0; i < 9; i++) exp_q.push_back(reg_tbl[i]);
    n = 0;
    while (rd_idx_q.size() < 9 && n < 1000) begin step(); n++; end
    n = 0;
    while (busy && n < 100) begin step(); n++; end
    total++; if (rd_idx_q.size() != 9) begin bad++; $display("FAIL burst_count: got %0d want 9", rd_idx_q.size()); end
    for (int i = 0; i < 9; i++) begin
      total++; if (rd_idx_q[i] !== 4'(i) || rd_data_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL burst_read%0d: idx=%0d data=%h want %0d/%h", i, rd_idx_q[i], rd_data_q[i], i, exp_q[i]);
      end
    end
    total++; if (rd_cyc_q[0] != rel + 221) begin bad++; $display("FAIL burst_first_time: got %0d want %0d", rd_cyc_q[0] - rel, 221); end
    for (int i = 1; i < 9; i++) begin
      total++; if (rd_cyc_q[i] - rd_cyc_q[i-1] != 24) begin bad++; $display("FAIL burst_spacing%0d: got %0d want 24", i, rd_cyc_q[i] - rd_cyc_q[i-1]); end
    end
    total++; if (cs_low - cs0 != 144) begin bad++; $display("FAIL burst_cs_low: got %0d want 144", cs_low - cs0); end
    total++; if (viol != 0) begin bad++; $display("FAIL burst_pins: got %0d violations want 0", viol); end
  endtask

  task automatic test_write_idle();
    int n;
    int c;
    int a0;
    a0      = ack_cnt;
    wr_addr = 8'h22;
    wr_data = 8'h45;
    wr_req  = 1'b1;
    c       = cyc;
    n = 0;
    while (ack_cnt == a0 && n < 60) begin step(); n++; end
    wr_req = 1'b0;
    total++; if (ack_cyc - c != 24) begin bad++; $display("FAIL wr_latency: got %0d want 24", ack_cyc - c); end
    total++; if (wr_seen_addr !== 8'h22 || wr_seen_data !== 8'h45) begin bad++; $display("FAIL wr_bus: addr=%h data=%h want 22/45", wr_seen_addr, wr_seen_data); end
    total++; if (a_len != 8 || d_len != 8) begin bad++; $display("FAIL wr_phase_len: addr=%0d data=%0d want 8/8", a_len, d_len); end
    repeat (30) step();
    total++; if (ack_cnt - a0 != 1) begin bad++; $display("FAIL wr_ack_once: got %0d want 1", ack_cnt - a0); end
  endtask

  task automatic test_write_mid_burst();
    int n;
    int a0;
    clear_obs();
    for (int i = 0; i < 9; i++) exp_q.push_back(reg_tbl[i]);
    exp_q[1] = 8'h45;
    exp_q[6] = 8'h5A;
    a0 = ack_cnt;
    n = 0;
    while (rd_idx_q.size() < 3 && n < 800) begin step(); n++; end
    repeat (6) step();
    wr_addr = 8'h31;
    wr_data = 8'h5A;
    wr_req  = 1'b1;
    n = 0;
    while ((rd_idx_q.size() < 9 || busy) && n < 600) begin
      step();
      n++;
      if (ack_cnt != a0) wr_req = 1'b0;
    end
    wr_req = 1'b0;
    total++; if (rd_idx_q.size() != 9) begin bad++; $display("FAIL mid_count: got %0d want 9", rd_idx_q.size()); end
    for (int i = 0; i < 9; i++) begin
      total++; if (rd_idx_q[i] !== 4'(i) || rd_data_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL mid_read%0d: idx=%0d data=%h want %0d/%h", i, rd_idx_q[i], rd_data_q[i], i, exp_q[i]);
      end
    end
    total++; if (ack_cnt - a0 != 1) begin bad++; $display("FAIL mid_ack_count: got %0d want 1", ack_cnt - a0); end
    total++; if (ack_cyc != rd_cyc_q[3] + 27) begin bad++; $display("FAIL mid_ack_slot: got %0d want %0d", ack_cyc - rd_cyc_q[3], 27); end
    total++; if (rd_cyc_q[4] != ack_cyc + 21) begin bad++; $display("FAIL mid_resume: got %0d want 21", rd_cyc_q[4] - ack_cyc); end
  endtask

  task automatic test_tick_and_write();
    int n;
    int c;
    int a0;
    clear_obs();
    a0 = ack_cnt;
    n = 0;
    while (((cyc - rel) % 200) != 199 && n < 600) begin step(); n++; end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL tick_idle: busy=%b want 0", busy); end
    wr_addr = 8'h26;
    wr_data = 8'h77;
    wr_req  = 1'b1;
    c       = cyc;
    n = 0;
    while ((rd_idx_q.size() < 9 || busy) && n < 600) begin
      step();
      n++;
      if (ack_cnt != a0) wr_req = 1'b0;
    end
    wr_req = 1'b0;
    total++; if (ack_cyc - c != 24) begin bad++; $display("FAIL tick_wr_first: got %0d want 24", ack_cyc - c); end
    total++; if (rd_cyc_q[0] != ack_cyc + 21) begin bad++; $display("FAIL tick_burst_after: got %0d want 21", rd_cyc_q[0] - ack_cyc); end
    total++; if (rd_idx_q.size() != 9) begin bad++; $display("FAIL tick_count: got %0d want 9", rd_idx_q.size()); end
    total++; if (rd_idx_q[5] !== 4'd5 || rd_data_q[5] !== 8'h77) begin bad++; $display("FAIL tick_read5: idx=%0d data=%h want 5/77", rd_idx_q[5], rd_data_q[5]); end
  endtask

  task automatic test_reset_mid_data();
    int n;
    n = 0;
    while (!(CS === 1'b0 && AD === 1'b1 && RD === 1'b0) && n < 600) begin step(); n++; end
    total++; if (RD !== 1'b0) begin bad++; $display("FAIL rst_found_data: RD=%b want 0", RD); end
    repeat (3) step();
    #2;
    reset = 1'b0;
    #1;
    total++; if ({CS, RD, WR, AD} !== 4'b1111) begin bad++; $display("FAIL rst_mid_strobes: got %b want 1111", {CS, RD, WR, AD}); end
    total++; if (dat_oe !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_mid_idle: oe=%b busy=%b want 0/0", dat_oe, busy); end
    repeat (2) step();
    reset = 1'b1;
    rel   = cyc;
    clear_obs();
    n = 0;
    while ((rd_idx_q.size() < 9 || busy) && n < 600) begin step(); n++; end
    total++; if (rd_idx_q[0] !== 4'd0 || rd_cyc_q[0] != rel + 221) begin
      bad++; $display("FAIL rst_restart: idx=%0d at %0d want 0 at 221", rd_idx_q[0], rd_cyc_q[0] - rel);
    end
    total++; if (rd_idx_q.size() != 9) begin bad++; $display("FAIL rst_count: got %0d want 9", rd_idx_q.size()); end
  endtask

  task automatic test_held_wr_req();
    int n;
    int a0;
    a0      = ack_cnt;
    wr_addr = 8'h21;
    wr_data = 8'h11;
    wr_req  = 1'b1;
    n = 0;
    while (ack_cnt == a0 && n < 60) begin step(); n++; end
    repeat (60) step();
    total++; if (ack_cnt - a0 != 1) begin bad++; $display("FAIL held_no_regrant: got %0d want 1", ack_cnt - a0); end
    wr_req = 1'b0;
    step();
    wr_data = 8'h12;
    wr_req  = 1'b1;
    n = 0;
    while (ack_cnt - a0 < 2 && n < 60) begin step(); n++; end
    wr_req = 1'b0;
    total++; if (ack_cnt - a0 != 2) begin bad++; $display("FAIL held_regrant: got %0d want 2", ack_cnt - a0); end
    total++; if (wr_seen_data !== 8'h12) begin bad++; $display("FAIL held_data: got %h want 12", wr_seen_data); end
    total++; if (oe_rd_viol != 0) begin bad++; $display("FAIL oe_while_rd: got %0d want 0", oe_rd_viol); end
    total++; if (viol != 0) begin bad++; $display("FAIL pin_rules: got %0d violations want 0", viol); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reg_tbl = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h31, 8'h32, 8'h33};
    test_reset();
    test_burst();
    test_write_idle();
    test_write_mid_burst();
    test_tick_and_write();
    test_reset_mid_data();
    test_held_wr_req();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
